// File: rtl/inst_axi_rd_bridge_pkg.sv
// inst_axi_rd_bridge_pkg: AR state encoding and fixed AXI read field values
package inst_axi_rd_bridge_pkg;
  typedef enum logic {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_t;
  localparam logic [7:0] AXI_LEN = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT = 3'd0;
endpackage

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: converts sram-like instruction fetches into single-beat in-order AXI reads
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [3:0] AR_ID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addrok,
  output logic        inst_sram_dataok,
  output logic [31:0] inst_sram_rdata,
  input  logic        cancel,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  ar_state_t     r_state;
  logic [31:0]   r_addr;
  logic [1:0]    r_size;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_drop_cnt;
  logic          w_accept;
  logic          w_unused;
  assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};
  assign w_accept = inst_sram_req && r_state == AR_IDLE && r_out_cnt < MAX_CNT && !cancel;
  assign inst_sram_addrok = w_accept;
  assign inst_sram_dataok = rvalid && r_drop_cnt == '0 && !cancel;
  assign inst_sram_rdata = rdata;
  assign arid = AR_ID;
  assign araddr = r_addr;
  assign arlen = AXI_LEN;
  assign arsize = {1'b0, r_size};
  assign arburst = AXI_BURST_INCR;
  assign arlock = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot = AXI_PROT;
  assign arvalid = r_state == AR_BUSY;
  assign rready = 1'b1;
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= inst_sram_addr;
      r_size <= inst_sram_size;
    end
    if (reset) begin
      r_state <= AR_IDLE;
      r_out_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_accept ? AR_BUSY : (arvalid && arready) ? AR_IDLE : r_state;
      r_out_cnt <= r_out_cnt + CW'(w_accept) - CW'(rvalid);
      // a flush makes every read still in flight stale, including one not yet issued
      r_drop_cnt <= cancel ? r_out_cnt - CW'(rvalid)
                  : (rvalid && r_drop_cnt != '0) ? r_drop_cnt - CW'(1) : r_drop_cnt;
    end
  end
endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// tb_inst_axi_rd_bridge: directed plus random fetch traffic checked against an in-flight transaction model
module tb_inst_axi_rd_bridge;
  localparam int MAX = 2;
  localparam logic [31:0] KEY = 32'h5a5a_a5a5;
  logic        clk = 0, reset = 1;
  logic        req = 0, cancel = 0, arready = 0, rvalid = 0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0, rdata = '0;
  logic        addrok, dataok, arvalid, rready;
  logic [31:0] srdata, araddr;
  logic [3:0]  arid, arcache;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  int n_chk = 0, n_err = 0;
  logic [31:0] q_addr[$];
  bit          q_stale[$];
  bit          ar_pend = 0;
  logic [31:0] ar_addr = '0;
  logic [1:0]  ar_size = '0;
  int          n_iss = 0;
  inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAX), .AR_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(req), .inst_sram_wr(1'b0), .inst_sram_size(size), .inst_sram_addr(addr),
    .inst_sram_wstrb(4'd0), .inst_sram_wdata(32'd0),
    .inst_sram_addrok(addrok), .inst_sram_dataok(dataok), .inst_sram_rdata(srdata),
    .cancel(cancel),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(4'd0), .rdata(rdata), .rresp(2'd0), .rlast(1'b1), .rvalid(rvalid), .rready(rready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    q_addr.delete();
    q_stale.delete();
    ar_pend = 0;
    n_iss = 0;
  endtask
  // one clock cycle: drive, check against the model, then advance the model
  task automatic cyc(input bit rq, input logic [31:0] a, input bit cn, input bit ardy,
                     input bit rv, input logic [31:0] rd);
    bit exp_acc, exp_dok;
    req = rq; addr = a; cancel = cn; arready = ardy; rvalid = rv; rdata = rd;
    #1;
    exp_acc = rq && !ar_pend && q_addr.size() < MAX && !cn;
    exp_dok = rv && q_addr.size() > 0 && !q_stale[0] && !cn;
    chk("addrok", 32'(addrok), 32'(exp_acc));
    chk("dataok", 32'(dataok), 32'(exp_dok));
    if (exp_dok) chk("rdata", srdata, rd);
    chk("arvalid", 32'(arvalid), 32'(ar_pend));
    if (ar_pend) begin
      chk("araddr", araddr, ar_addr);
      chk("arsize", 32'(arsize), {30'd0, ar_size});
      chk("ar_const", {arid, arlen, arburst, arlock, arcache, arprot, rready},
          {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});
    end
    if (ar_pend && ardy) begin ar_pend = 0; n_iss++; end
    if (rv && q_addr.size() > 0) begin
      void'(q_addr.pop_front());
      void'(q_stale.pop_front());
      n_iss--;
    end
    if (cn) foreach (q_stale[i]) q_stale[i] = 1;
    if (exp_acc) begin
      q_addr.push_back(a); q_stale.push_back(0);
      ar_pend = 1; ar_addr = a; ar_size = size;
    end
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    req = 0; cancel = 0; arready = 0; rvalid = 0; reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
  endtask
  initial begin
    @(posedge clk); #1;
    do_reset();
    #1;
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_addrok", 32'(addrok), 0);
    chk("rst_dataok", 32'(dataok), 0);
    chk("rst_rready", 32'(rready), 1);
    // single fetch, zero-wait slave one cycle late
    cyc(1, 32'hbfc00000, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h3c1d0000);
    // AR backpressure with a competing request
    cyc(1, 32'hbfc00004, 0, 0, 0, 0);
    repeat (4) cyc(1, 32'hbfc00008, 0, 0, 0, 0);
    cyc(1, 32'hbfc00008, 0, 1, 0, 0);
    cyc(1, 32'hbfc00008, 0, 0, 0, 0);
    chk("bp_out_cnt", q_addr.size(), 2);
    // outstanding cap reached
    cyc(1, 32'hbfc0000c, 0, 1, 0, 0);
    cyc(1, 32'hbfc0000c, 0, 0, 1, 32'h0000_0001);
    cyc(1, 32'hbfc0000c, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0000_0002);
    cyc(0, 0, 0, 0, 1, 32'h0000_0003);
    // cancel with two in flight, third fetch after the flush
    cyc(1, 32'hbfc00010, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'hbfc00014, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h11111111);
    cyc(1, 32'hbfc00018, 0, 0, 1, 32'h22222222);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h33333333);
    // cancel colliding with rvalid at one outstanding
    cyc(1, 32'hbfc0001c, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'hbfc00020, 1, 0, 1, 32'h44444444);
    cyc(1, 32'hbfc00020, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h55555555);
    // reset while AR_BUSY with one outstanding
    cyc(1, 32'hbfc00024, 0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'hbfc00000, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h3c1d0000);
    // random traffic
    for (int c = 0; c < 2000; c++) begin
      bit rv;
      logic [31:0] rd;
      rv = n_iss > 0 && $urandom_range(0, 9) < 6;
      rd = rv ? (q_addr[0] ^ KEY) : $urandom;
      size = 2'($urandom_range(0, 2));
      cyc($urandom_range(0, 9) < 6, {$urandom, 2'b00} & 32'hffff_fffc,
          $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, rv, rd);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
Sits between if_stage's instruction sram-like port and the AXI read channels: it feeds the pre-IF/IF pair and consumes their requests. Each accepted fetch becomes one single-beat AXI read, and each read's data is returned in order. Up to MAX_OUTSTANDING reads may be in flight. A cancel input discards responses for fetches made stale by an exception flush.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-unreturned reads (1..7).
AR_ID, 4'd0, constant arid; all reads use the same ID, so responses return in order.

Ports:
clk  in  1  clock.
reset  in  1  reset; synchronous, active-high.
inst_sram_req  in  1  fetch request.
inst_sram_wr  in  1  must be 0; ignored.
inst_sram_size  in  2  drives arsize[1:0].
inst_sram_addr  in  32  fetch address.
inst_sram_wstrb  in  4  ignored.
inst_sram_wdata  in  32  ignored.
inst_sram_addrok  out  1  request accepted this cycle.
inst_sram_dataok  out  1  rdata valid this cycle.
inst_sram_rdata  out  32  instruction word.
cancel  in  1  flush pulse, tied to ws_handle_ex.
arid  out  4  = AR_ID.
araddr  out  32  read address.
arlen  out  8  = 0.
arsize  out  3  = {1'b0, latched size}.
arburst  out  2  = 2'b01.
arlock  out  2  = 0.
arcache  out  4  = 0.
arprot  out  3  = 0.
arvalid  out  1  AR valid.
arready  in  1  AR ready.
rid  in  4  ignored.
rdata  in  32  read data.
rresp  in  2  ignored.
rlast  in  1  ignored; single beat.
rvalid  in  1  R valid.
rready  out  1  constant 1.

Behaviour:
- AR FSM with two states.
  - AR_IDLE: arvalid=0.
  - AR_IDLE -> AR_BUSY when accepting: latch inst_sram_addr and inst_sram_size.
  - AR_BUSY: arvalid=1 with araddr/arsize held stable until arready.
  - AR_BUSY -> AR_IDLE on arvalid&&arready.
- Accept rule: inst_sram_addrok = inst_sram_req && state==AR_IDLE && out_cnt<MAX_OUTSTANDING && !cancel.
  - addrok is combinational, in the same cycle as req.
  - arvalid is asserted from the next cycle.
  - An AR handshake and a new accept never occur in the same cycle.
- out_cnt tracks accepted reads whose R beat has not arrived.
  - +1 on addrok, -1 on rvalid (rready=1).
  - Both in one cycle: out_cnt unchanged.
  - Width is clog2(MAX_OUTSTANDING+1).
- drop_cnt tracks R beats still to be discarded; drop_cnt <= out_cnt always holds.
- R path:
  - inst_sram_rdata = rdata, combinational.
  - inst_sram_dataok = rvalid && drop_cnt==0 && !cancel.
  - A beat arriving while drop_cnt>0 decrements drop_cnt and produces no dataok.
- On cancel:
  - No accept occurs that cycle.
  - Any rvalid beat that cycle is discarded.
  - drop_cnt <= out_cnt - rvalid, i.e. every remaining in-flight read, including one latched in AR_BUSY and not yet issued.
  - A pending AR is never retracted; it completes normally.
  - Repeated cancel while draining recomputes drop_cnt by the same rule.
- Minimum latency from addrok to dataok is 2 cycles (AR issued at +1, R at +2 with a zero-wait slave).
- Reset:
  - State AR_IDLE, out_cnt=0, drop_cnt=0.
  - Outputs: arvalid=0, addrok=0, dataok=0, rready=1.
  - Reset mid-transfer abandons all in-flight reads; the AXI slave is reset together with this block.

Decomposition:
- mycpu.h: AR_IDLE/AR_BUSY encodings, AXI constant field values (burst INCR, len 0).
- No sub-module; a small counter-pair block is optional but unnecessary.

Test Plan:
- Single fetch: req addr 0xbfc00000 at cycle 0; arready=1 at cycle 1; rvalid with rdata 0x3c1d0000 at cycle 3 -> addrok at 0, arvalid at 1 with araddr 0xbfc00000, arlen 0, arsize 2; dataok only at 3 with rdata 0x3c1d0000.
- AR backpressure: arready low for 4 cycles -> arvalid/araddr stable throughout; a second req gets addrok=0 until the handshake cycle has passed.
- Outstanding cap (MAX=2): two reads accepted, no R -> third req addrok=0; after one rvalid, addrok=1 the next cycle.
- Cancel draining: out_cnt=2, cancel pulse, then R beats 0x11111111, 0x22222222, 0x33333333 (third fetched after cancel) -> only 0x33333333 produces dataok.
- Cancel colliding with rvalid at out_cnt=1 -> no dataok that cycle, drop_cnt=0 after, out_cnt=0; a req asserted the same cycle gets addrok=0.
- Reset mid-operation: reset while AR_BUSY with out_cnt=1 -> next cycle arvalid=0, out_cnt=0, dataok=0; a fresh fetch then completes as in the first scenario.
